// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, direction codes and the link-index mapping.
package router_pkg;

    localparam int FLIT_SIZE = 82;
    localparam int ROUTE_LEN = 3;
    localparam int VALID_BIT = 81;
    localparam int NUM_LINKS = 6;

    localparam logic [ROUTE_LEN-1:0] DIR_INJECT = 3'd0;
    localparam logic [ROUTE_LEN-1:0] DIR_XPOS   = 3'd1;
    localparam logic [ROUTE_LEN-1:0] DIR_YPOS   = 3'd2;
    localparam logic [ROUTE_LEN-1:0] DIR_ZPOS   = 3'd3;
    localparam logic [ROUTE_LEN-1:0] DIR_XNEG   = 3'd4;
    localparam logic [ROUTE_LEN-1:0] DIR_YNEG   = 3'd5;
    localparam logic [ROUTE_LEN-1:0] DIR_ZNEG   = 3'd6;
    localparam logic [ROUTE_LEN-1:0] DIR_EJECT  = 3'd7;

    typedef struct packed {
        logic [FLIT_SIZE-1:0] flit;
        logic [ROUTE_LEN-1:0] route;
    } hold_t;

    // Link directions 1..6 map to credit index 0..5; INJECT/EJECT land outside that range.
    function automatic logic [ROUTE_LEN-1:0] dir_to_link(input logic [ROUTE_LEN-1:0] dir);
        return dir - 3'd1;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-link downstream credit counter; saturates at CREDIT_MAX and flags an extra return.
module credit_counter #(
    parameter int CREDIT_MAX = 16,
    parameter int CREDIT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic dec,
    input  logic inc,
    output logic avail,
    output logic overflow
);

    logic [CREDIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        overflow = 1'b0;
        unique case ({inc, dec})
            2'b10: begin
                if (cnt_q == CREDIT_W'(CREDIT_MAX)) overflow = 1'b1;
                else                                 cnt_d    = cnt_q + CREDIT_W'(1);
            end
            2'b01: if (cnt_q != '0) cnt_d = cnt_q - CREDIT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= CREDIT_W'(CREDIT_MAX);
        else     cnt_q <= cnt_d;
    end

    assign avail = (cnt_q != '0);

endmodule

// File: rtl/va_stage.sv
// Per-input VC allocation stage: one holding register, credit-gated request to the switch allocator.
// Optional VA_STAGE_PERF_EN adds forwarded-flit and stall-cycle counters.
module va_stage
    import router_pkg::*;
#(
    parameter int CREDIT_MAX = 16,
    parameter int CREDIT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] flit_in,
    input  logic                 flit_in_valid,
    input  logic [ROUTE_LEN-1:0] route_in,
    output logic                 stall,
    output logic [FLIT_SIZE-1:0] flit_out,
    output logic [ROUTE_LEN-1:0] route_out,
    output logic                 flit_out_valid,
    input  logic                 sa_grant,
    input  logic [NUM_LINKS-1:0] credit_return,
    output logic [NUM_LINKS-1:0] credit_avail,
    output logic [1:0]           err_sticky
`ifdef VA_STAGE_PERF_EN
    ,
    output logic [31:0]          perf_fwd_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    logic                 hold_valid_q, hold_valid_d;
    hold_t                hold_q, hold_d;
    logic [1:0]           err_q, err_d;
    logic [NUM_LINKS-1:0] link_sel, dec, ovf;
    logic                 ok, rel, accept, illegal;

    always_comb begin
        // EJECT and INJECT shift the one-hot past the top, so they never touch a counter.
        link_sel       = NUM_LINKS'(1) << dir_to_link(hold_q.route);
        ok             = (hold_q.route == DIR_EJECT) || (|(link_sel & credit_avail));
        flit_out_valid = hold_valid_q & ok;
        rel            = flit_out_valid & sa_grant;
        dec            = rel ? link_sel : '0;
        // Holding off upstream during reset keeps its flit from being consumed and lost.
        stall          = rst | (hold_valid_q & ~rel);
        accept         = flit_in_valid & ~stall;
        illegal        = accept & (route_in == DIR_INJECT);

        hold_valid_d = hold_valid_q & ~rel;
        hold_d       = hold_q;
        if (accept && !illegal) begin
            hold_valid_d = 1'b1;
            hold_d       = '{flit: flit_in, route: route_in};
        end
        err_d = err_q | {illegal, |ovf};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            err_q        <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            err_q        <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
        credit_counter #(
            .CREDIT_MAX(CREDIT_MAX),
            .CREDIT_W  (CREDIT_W)
        ) u_cc (
            .clk     (clk),
            .rst     (rst),
            .dec     (dec[i]),
            .inc     (credit_return[i]),
            .avail   (credit_avail[i]),
            .overflow(ovf[i])
        );
    end

    assign flit_out   = hold_q.flit;
    assign route_out  = hold_q.route;
    assign err_sticky = err_q;

`ifdef VA_STAGE_PERF_EN
    logic [31:0] perf_fwd_q, perf_fwd_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fwd_d   = perf_fwd_q + {31'd0, rel};
        perf_stall_d = perf_stall_q + {31'd0, stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fwd_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fwd_q   <= perf_fwd_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fwd_cnt   = perf_fwd_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_va_stage.sv
// Directed bench for va_stage with a scoreboard of granted flits.
module tb_va_stage;
    import router_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [FLIT_SIZE-1:0] flit_in;
    logic                 flit_in_valid;
    logic [ROUTE_LEN-1:0] route_in;
    logic                 stall;
    logic [FLIT_SIZE-1:0] flit_out;
    logic [ROUTE_LEN-1:0] route_out;
    logic                 flit_out_valid;
    logic                 sa_grant;
    logic [5:0]           credit_return;
    logic [5:0]           credit_avail;
    logic [1:0]           err_sticky;

    int checks   = 0;
    int failures = 0;
    int seq      = 0;
    logic [FLIT_SIZE+ROUTE_LEN-1:0] sb_q[$];

    always #5 clk = ~clk;

    va_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flit_in       (flit_in),
        .flit_in_valid (flit_in_valid),
        .route_in      (route_in),
        .stall         (stall),
        .flit_out      (flit_out),
        .route_out     (route_out),
        .flit_out_valid(flit_out_valid),
        .sa_grant      (sa_grant),
        .credit_return (credit_return),
        .credit_avail  (credit_avail),
        .err_sticky    (err_sticky)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FLIT_SIZE-1:0] mk_flit(input int s);
        return {1'b1, 17'(s), 32'hA5A50000 | 32'(s), 32'(s * 7 + 3)};
    endfunction

    // Drive one flit this cycle and record it as expected on the output.
    task automatic drive(input logic [ROUTE_LEN-1:0] r);
        seq++;
        flit_in       = mk_flit(seq);
        route_in      = r;
        flit_in_valid = 1'b1;
        if (r != DIR_INJECT) sb_q.push_back({flit_in, r});
    endtask

    task automatic burst(input logic [ROUTE_LEN-1:0] r, input int n, input string tag);
        sa_grant = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(r);
            @(negedge clk);
            chk(tag, stall, 1'b0);
            tick();
        end
        flit_in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic ret_credits(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            credit_return      = '0;
            credit_return[idx] = 1'b1;
            tick();
        end
        credit_return = '0;
    endtask

    // Scoreboard: every grant of a valid request must match the oldest outstanding flit.
    always @(negedge clk) begin
        if (!rst && flit_out_valid && sa_grant) begin
            if (sb_q.size() == 0) begin
                chk("spurious_release", 1'b1, 1'b0);
            end else begin
                logic [FLIT_SIZE+ROUTE_LEN-1:0] e;
                e = sb_q.pop_front();
                chk("sb_flit", flit_out, e[FLIT_SIZE+ROUTE_LEN-1:ROUTE_LEN]);
                chk("sb_route", route_out, e[ROUTE_LEN-1:0]);
            end
        end
    end

    initial begin
        logic exp_held, exp_stall, acc, g;
        int   sent;

        rst = 1'b1; flit_in = '0; flit_in_valid = 1'b0; route_in = '0;
        sa_grant = 1'b0; credit_return = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_fov", flit_out_valid, 1'b0);
        chk("rst_flit", flit_out, '0);
        chk("rst_route", route_out, '0);
        chk("rst_avail", credit_avail, 6'h3f);
        chk("rst_err", err_sticky, 2'b00);
        tick();

        // Single XPOS flit with grant tied high: one-cycle latency.
        sa_grant = 1'b1;
        drive(DIR_XPOS);
        @(negedge clk); chk("t1_stall0", stall, 1'b0);
        tick(); flit_in_valid = 1'b0;
        @(negedge clk); chk("t1_fov", flit_out_valid, 1'b1); chk("t1_stall1", stall, 1'b0);
        tick();
        @(negedge clk); chk("t1_fov_off", flit_out_valid, 1'b0); chk("t1_avail", credit_avail, 6'h3f);
        tick();

        // Exhaust XPOS credit (15 left): the 16th flit of this burst is held without credit.
        for (int i = 0; i < 16; i++) begin
            drive(DIR_XPOS);
            @(negedge clk); chk("t2_burst_stall", stall, 1'b0);
            tick();
        end
        flit_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_held_fov", flit_out_valid, 1'b0);
            chk("t2_held_stall", stall, 1'b1);
            chk("t2_avail0", credit_avail[0], 1'b0);
            tick();
        end
        credit_return = 6'b000001;
        @(negedge clk); chk("t2_ret_fov", flit_out_valid, 1'b0);
        tick(); credit_return = '0;
        @(negedge clk); chk("t2_rel_fov", flit_out_valid, 1'b1); chk("t2_rel_stall", stall, 1'b0);
        tick();
        @(negedge clk); chk("t2_after_fov", flit_out_valid, 1'b0); chk("t2_after_avail0", credit_avail[0], 1'b0);
        ret_credits(0, 16);
        @(negedge clk); chk("t2_refill_avail", credit_avail, 6'h3f); chk("t2_refill_err", err_sticky, 2'b00);
        tick();

        // Back-to-back EJECT with toggling grant; model held/stall independently.
        exp_held = 1'b0; sent = 0;
        for (int c = 0; c < 30 && (sent < 6 || exp_held); c++) begin
            g = (c % 2) == 1;
            sa_grant = g;
            if (sent < 6) begin
                seq++;
                flit_in = mk_flit(seq); route_in = DIR_EJECT; flit_in_valid = 1'b1;
            end else begin
                flit_in_valid = 1'b0;
            end
            exp_stall = exp_held & ~g;
            acc = flit_in_valid & ~exp_stall;
            if (acc) begin
                sb_q.push_back({flit_in, DIR_EJECT});
                sent++;
            end
            @(negedge clk);
            chk("t3_stall", stall, exp_stall);
            chk("t3_fov", flit_out_valid, exp_held);
            exp_held = acc | (exp_held & ~g);
            tick();
        end
        flit_in_valid = 1'b0;
        @(negedge clk); chk("t3_sent", sent, 6); chk("t3_avail", credit_avail, 6'h3f);
        tick();

        // YNEG: release and return together leave credit at max; a further return overflows.
        sa_grant = 1'b0;
        drive(DIR_YNEG);
        tick(); flit_in_valid = 1'b0;
        @(negedge clk); chk("t4_fov", flit_out_valid, 1'b1); chk("t4_stall", stall, 1'b1);
        tick();
        sa_grant = 1'b1; credit_return = 6'b010000;
        tick();
        sa_grant = 1'b0; credit_return = '0;
        @(negedge clk); chk("t4_same_err", err_sticky, 2'b00); chk("t4_same_fov", flit_out_valid, 1'b0);
        tick();
        ret_credits(4, 1);
        @(negedge clk); chk("t4_ovf_err", err_sticky, 2'b01);
        tick();
        burst(DIR_YNEG, 16, "t4_burst_stall");
        @(negedge clk); chk("t4_drained_avail", credit_avail, 6'b101111);
        ret_credits(4, 16);
        @(negedge clk); chk("t4_refill_avail", credit_avail, 6'h3f); chk("t4_err_kept", err_sticky, 2'b01);
        tick();

        // Illegal INJECT route is dropped; the next flit goes through.
        sa_grant = 1'b1;
        drive(DIR_INJECT);
        @(negedge clk); chk("t5_inj_stall", stall, 1'b0);
        tick();
        drive(DIR_EJECT);
        @(negedge clk);
        chk("t5_inj_fov", flit_out_valid, 1'b0); chk("t5_inj_err", err_sticky, 2'b11);
        chk("t5_inj_stall2", stall, 1'b0);
        tick(); flit_in_valid = 1'b0;
        @(negedge clk); chk("t5_next_fov", flit_out_valid, 1'b1); chk("t5_next_route", route_out, DIR_EJECT);
        tick();

        // Reset while holding an XPOS flit with XPOS credit at 3.
        burst(DIR_XPOS, 13, "t6_burst_stall");
        sa_grant = 1'b0;
        drive(DIR_XPOS);
        tick(); flit_in_valid = 1'b0;
        @(negedge clk); chk("t6_held_stall", stall, 1'b1); chk("t6_held_fov", flit_out_valid, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("t6_stall", stall, 1'b0);
        chk("t6_fov", flit_out_valid, 1'b0);
        chk("t6_flit", flit_out, '0);
        chk("t6_route", route_out, '0);
        chk("t6_avail", credit_avail, 6'h3f);
        chk("t6_err", err_sticky, 2'b00);
        tick();
        burst(DIR_XPOS, 16, "t6_full_burst_stall");
        @(negedge clk); chk("t6_full_credit", credit_avail, 6'b111110);

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
